// File: rtl/arb_seq_ctrl.sv
// Arbitrary-sequence counter controller: plays a 16-entry table onto Out with start/stop/step control.
// Optional ARB_SEQ_LOOP_CNT_EN adds a loops input so one-shot play repeats the sequence loops+1 times.
module arb_seq_ctrl #(
  parameter int DIV_W = 8,
  parameter logic [3:0] RST_LAST = 4'd9
) (
  input  logic             C,
  input  logic             nR,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             len_wr,
  input  logic [3:0]       len_data,
  input  logic [DIV_W-1:0] div,
  input  logic             mode,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_step,
`ifdef ARB_SEQ_LOOP_CNT_EN
  input  logic [3:0]       loops,
`endif
  output logic [3:0]       Out,
  output logic             busy,
  output logic             step_pulse,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] RST_TBL [16] = '{4'd8, 4'd2, 4'd11, 4'd7, 4'd14, 4'd1, 4'd4, 4'd8,
                                          4'd4, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  state_t state, state_nxt;
  logic [3:0] tbl [16];
  logic [3:0] last_idx;
  logic [3:0] cur_idx;
  logic [DIV_W-1:0] timer;
  logic mode_q;
  logic at_last, last_pass;
  logic load_start, abort, advance, reload, finish, timer_dec;

  // >= rather than == so that shrinking last_idx below cur_idx still wraps cleanly
  assign at_last = (cur_idx >= last_idx);

`ifdef ARB_SEQ_LOOP_CNT_EN
  logic [3:0] loop_cnt;
  assign last_pass = at_last && (loop_cnt == 4'd0);
`else
  assign last_pass = at_last;
`endif

  assign busy = (state == RUN);

  always_ff @(posedge C or negedge nR) begin
    if (!nR) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    abort      = 1'b0;
    advance    = 1'b0;
    reload     = 1'b0;
    finish     = 1'b0;
    timer_dec  = 1'b0;
    if (cmd_stop) begin
      state_nxt = IDLE;
      abort     = 1'b1;
    end else if (cmd_start) begin
      state_nxt  = RUN;
      load_start = 1'b1;
    end else begin
      case (state)
        IDLE: advance = cmd_step;
        DONE: begin
          if (cmd_step) begin
            advance   = 1'b1;
            state_nxt = IDLE;
          end
        end
        RUN: begin
          if (timer == '0) begin
            if (mode_q && last_pass) begin
              finish    = 1'b1;
              state_nxt = DONE;
            end else begin
              advance = 1'b1;
              reload  = 1'b1;
            end
          end else begin
            timer_dec = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Table and length registers accept writes regardless of playback state
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < 16; i++) tbl[i] <= RST_TBL[i];
      last_idx <= RST_LAST;
    end else begin
      if (wr_en)  tbl[wr_addr] <= wr_data;
      if (len_wr) last_idx <= len_data;
    end
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      cur_idx    <= RST_LAST;
      Out        <= 4'd0;
      timer      <= '0;
      mode_q     <= 1'b0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
`ifdef ARB_SEQ_LOOP_CNT_EN
      loop_cnt   <= 4'd0;
`endif
    end else begin
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      done       <= finish;
      if (load_start) begin
        cur_idx    <= 4'd0;
        Out        <= tbl[0];
        step_pulse <= 1'b1;
        timer      <= div;
        mode_q     <= mode;
`ifdef ARB_SEQ_LOOP_CNT_EN
        loop_cnt   <= loops;
`endif
      end else if (abort) begin
        cur_idx <= last_idx;
      end else if (advance) begin
        step_pulse <= 1'b1;
        if (at_last) begin
          cur_idx <= 4'd0;
          Out     <= tbl[0];
          wrap    <= 1'b1;
`ifdef ARB_SEQ_LOOP_CNT_EN
          if (reload && mode_q) loop_cnt <= loop_cnt - 4'd1;
`endif
        end else begin
          cur_idx <= cur_idx + 4'd1;
          Out     <= tbl[cur_idx + 4'd1];
        end
        if (reload) timer <= div;
      end else if (timer_dec) begin
        timer <= timer - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_seq_ctrl.sv
// Directed self-checking bench for arb_seq_ctrl; define ARB_SEQ_LOOP_CNT_EN to also cover loop counting.
module tb_arb_seq_ctrl;

  logic C = 1'b0;
  logic nR;
  logic wr_en, len_wr, mode, cmd_start, cmd_stop, cmd_step;
  logic [3:0] wr_addr, wr_data, len_data;
  logic [7:0] div;
`ifdef ARB_SEQ_LOOP_CNT_EN
  logic [3:0] loops;
`endif
  logic [3:0] Out;
  logic busy, step_pulse, wrap, done;

  int compared = 0;
  int mismatched = 0;
  int wraps;
  logic [3:0] seq [10] = '{4'd8, 4'd2, 4'd11, 4'd7, 4'd14, 4'd1, 4'd4, 4'd8, 4'd4, 4'd15};
  logic [3:0] stepSeq [5] = '{4'd8, 4'd2, 4'd11, 4'd5, 4'd8};

  arb_seq_ctrl #(.DIV_W(8), .RST_LAST(4'd9)) dut (
    .C(C), .nR(nR),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_wr(len_wr), .len_data(len_data),
    .div(div), .mode(mode),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
`ifdef ARB_SEQ_LOOP_CNT_EN
    .loops(loops),
`endif
    .Out(Out), .busy(busy), .step_pulse(step_pulse), .wrap(wrap), .done(done)
  );

  always #5 C = ~C;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge C);
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic step);
    cmd_start = start;
    cmd_stop  = stop;
    cmd_step  = step;
    cycle();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_step  = 1'b0;
  endtask

  task automatic applyReset();
    nR = 1'b0;
    cycle();
    nR = 1'b1;
    cycle();
  endtask

  initial begin
    nR = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; len_wr = 0; len_data = 0;
    div = 0; mode = 0; cmd_start = 0; cmd_stop = 0; cmd_step = 0;
`ifdef ARB_SEQ_LOOP_CNT_EN
    loops = 0;
`endif
    #3;
    checkOutput("rst_out", {4'd0, Out}, 8'd0);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_step", {7'd0, step_pulse}, 8'd0);
    checkOutput("rst_wrap", {7'd0, wrap}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    cycle();
    nR = 1'b1;
    cycle();

    $display("[TB] continuous play, div=0");
    mode = 0; div = 0;
    applyStimulus(1, 0, 0);
    checkOutput("cont_step0", {7'd0, step_pulse}, 8'd1);
    for (int k = 0; k < 12; k++) begin
      checkOutput("cont_out", {4'd0, Out}, {4'd0, seq[k % 10]});
      checkOutput("cont_wrap", {7'd0, wrap}, (k == 10) ? 8'd1 : 8'd0);
      checkOutput("cont_busy", {7'd0, busy}, 8'd1);
      cycle();
    end

    $display("[TB] one-shot play, div=1");
    applyReset();
    mode = 1; div = 1;
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      checkOutput("oneshot_out", {4'd0, Out}, {4'd0, seq[k / 2]});
      checkOutput("oneshot_done", {7'd0, done}, 8'd0);
      checkOutput("oneshot_busy", {7'd0, busy}, 8'd1);
      cycle();
    end
    checkOutput("oneshot_done_hi", {7'd0, done}, 8'd1);
    checkOutput("oneshot_busy_lo", {7'd0, busy}, 8'd0);
    checkOutput("oneshot_out_end", {4'd0, Out}, 8'd15);
    checkOutput("oneshot_nowrap", {7'd0, wrap}, 8'd0);
    cycle();
    checkOutput("oneshot_done_lo", {7'd0, done}, 8'd0);
    checkOutput("oneshot_hold", {4'd0, Out}, 8'd15);

    $display("[TB] table and length rewrite, single steps");
    applyReset();
    wr_en = 1; wr_addr = 4'd3; wr_data = 4'd5; len_wr = 1; len_data = 4'd3;
    cycle();
    wr_en = 0; len_wr = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput("step_out", {4'd0, Out}, {4'd0, stepSeq[k]});
      checkOutput("step_pulse", {7'd0, step_pulse}, 8'd1);
      checkOutput("step_busy", {7'd0, busy}, 8'd0);
      if (k > 0) checkOutput("step_wrap", {7'd0, wrap}, (k == 4) ? 8'd1 : 8'd0);
    end

    $display("[TB] stop beats start");
    applyReset();
    mode = 0; div = 3;
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 8; k++) cycle();
    checkOutput("div3_out", {4'd0, Out}, 8'd11);
    applyStimulus(1, 1, 0);
    checkOutput("stop_busy", {7'd0, busy}, 8'd0);
    checkOutput("stop_out", {4'd0, Out}, 8'd11);
    cycle();
    checkOutput("stop_hold", {4'd0, Out}, 8'd11);
    applyStimulus(0, 0, 1);
    checkOutput("stop_step_out", {4'd0, Out}, 8'd8);
    checkOutput("stop_step_wrap", {7'd0, wrap}, 8'd1);

    $display("[TB] async reset mid-run");
    applyReset();
    mode = 0; div = 0;
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 4; k++) cycle();
    checkOutput("pre_rst_out", {4'd0, Out}, 8'd14);
    #2 nR = 1'b0;
    #1;
    checkOutput("async_rst_out", {4'd0, Out}, 8'd0);
    checkOutput("async_rst_busy", {7'd0, busy}, 8'd0);
    cycle();
    nR = 1'b1;
    cycle();
    applyStimulus(1, 0, 0);
    checkOutput("post_rst_out", {4'd0, Out}, 8'd8);
    checkOutput("post_rst_busy", {7'd0, busy}, 8'd1);

`ifdef ARB_SEQ_LOOP_CNT_EN
    $display("[TB] one-shot with loops=2");
    applyReset();
    mode = 1; div = 0; loops = 4'd2;
    applyStimulus(1, 0, 0);
    wraps = 0;
    for (int k = 0; k < 30; k++) begin
      checkOutput("loop_out", {4'd0, Out}, {4'd0, seq[k % 10]});
      checkOutput("loop_wrap", {7'd0, wrap}, (k == 10 || k == 20) ? 8'd1 : 8'd0);
      checkOutput("loop_done", {7'd0, done}, 8'd0);
      if (wrap) wraps++;
      cycle();
    end
    checkOutput("loop_wraps", wraps[7:0], 8'd2);
    checkOutput("loop_done_hi", {7'd0, done}, 8'd1);
    checkOutput("loop_out_end", {4'd0, Out}, 8'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arb_seq_ctrl.md
Name: arb_seq_ctrl

Overview:
- Programmable sequencer that drives a 4-bit arbitrary-count output from a loadable table of up to 16 entries.
- It is the controller for the arbitrary-sequence counter datapath. It adds start, stop and single-step control, a step-rate divider, continuous or one-shot play, and table and length reprogramming.
- Reset contents reproduce the team's standard sequence: 8 2 11 7 14 1 4 8 4 15.

Parameters:
- DIV_W, 8, width of the step-period divider input.
- RST_LAST, 9, reset value of last_idx, giving a 10-entry sequence.

Ports:
- C  input  1  clock; all state changes on rising edge.
- nR  input  1  asynchronous active-low reset.
- wr_en  input  1  table write strobe.
- wr_addr  input  4  table entry address.
- wr_data  input  4  table entry data.
- len_wr  input  1  load last_idx from len_data.
- len_data  input  4  new last_idx (sequence length minus 1).
- div  input  DIV_W  step period = div+1 cycles; sampled at start and at every reload.
- mode  input  1  0 = continuous, 1 = one-shot; sampled at start.
- cmd_start  input  1  begin play from entry 0.
- cmd_stop  input  1  abort to IDLE.
- cmd_step  input  1  single advance, IDLE/DONE only.
- Out  output  4  current sequence value (registered).
- busy  output  1  high in RUN.
- step_pulse  output  1  one cycle, high on each cycle Out is loaded.
- wrap  output  1  one cycle, high when Out loads entry 0 via wrap from last_idx.
- done  output  1  one cycle, high on the RUN->DONE transition.

Behaviour:
- Async reset (nR=0):
  - Table = {8,2,11,7,14,1,4,8,4,15,0,0,0,0,0,0}; last_idx = RST_LAST.
  - cur_idx = last_idx, so the next advance yields entry 0.
  - Out=0, timer=0, state IDLE, all pulses 0.
  - Reset mid-run aborts immediately.
- Advance rule, at one clock edge:
  - If cur_idx >= last_idx: cur_idx<=0, Out<=table[0], wrap=1.
  - Else: cur_idx<=cur_idx+1, Out<=table[cur_idx+1].
  - Either way, step_pulse=1.
  - The >= comparison makes shrinking last_idx mid-run safe.
- Command priority: cmd_stop > cmd_start > cmd_step; lower-priority commands in the same cycle are ignored.
- IDLE:
  - start -> RUN; cur_idx<=0, Out<=table[0], step_pulse=1, timer<=div, mode latched. Latency is 1 cycle.
  - step -> apply advance rule, stay IDLE.
- RUN:
  - timer decrements each cycle.
  - At timer==0: apply advance rule and reload timer<=div (current input).
  - One-shot, at timer==0 with cur_idx>=last_idx: go to DONE instead; done=1, Out holds, no wrap pulse.
  - div=0 advances every cycle.
  - stop -> IDLE; Out holds, cur_idx<=last_idx.
  - start in RUN restarts from entry 0.
  - step is ignored in RUN.
- DONE:
  - Same as IDLE, except start reuses DONE->RUN and step behaves as in IDLE, moving to IDLE.
- Table write (wr_en) is accepted in any state.
  - Affects only future loads; Out is never rewritten retroactively.
  - A write and a read of the same entry in the same cycle returns the old data.
- len_wr takes effect next cycle; cur_idx is unchanged.
- wr_en and len_wr in the same cycle: both apply.

Optional Feature:
- Macro: ARB_SEQ_LOOP_CNT_EN.
- Enabled:
  - Adds input loops[3:0], sampled at start.
  - One-shot plays the full sequence loops+1 times. Intermediate passes wrap with wrap=1; DONE only after the final pass.
  - Continuous mode ignores loops.
- Disabled: port absent; one-shot plays exactly once.

Test Plan:
- Reset, start, mode=0, div=0 -> Out = 8,2,11,7,14,1,4,8,4,15,8,2...; one value per cycle; wrap=1 on each 15->8 load; busy=1 throughout.
- Reset, mode=1, div=1, start -> each value held 2 cycles; after 15 is held 2 cycles, done=1 for one cycle, busy=0, Out stays 15.
- Reset, then write entry 3=5 and len_data=3; issue cmd_step x5 -> Out = 8,2,11,5,8; wrap=1 on the 5th step.
- Run continuous with div=3; assert cmd_stop and cmd_start in the same cycle while Out=11 -> IDLE, Out holds 11; next cmd_step gives Out=8.
- Pull nR low mid-run with Out=14 -> Out=0 and busy=0 immediately (asynchronously); after release, start -> Out=8.
- With ARB_SEQ_LOOP_CNT_EN, loops=2, mode=1, div=0 -> 30 values, wrap=1 twice, then done=1, Out=15.
